// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types and BCD helpers for the RTC adjust counters
package rtc_pkg;

  typedef enum logic [1:0] {IDLE, FIRST, REPEAT} press_state_t;

  typedef enum logic [3:0] {
    SEL_SEG  = 4'd8,
    SEL_MIN  = 4'd9,
    SEL_HORA = 4'd10,
    SEL_DIA  = 4'd11,
    SEL_MES  = 4'd12,
    SEL_ANIO = 4'd13
  } sel_code_t;

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] to_bcd2(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  function automatic int bcd_value(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  // Signed integer compare keeps a MOD_MIN of 0 from becoming a constant-true test.
  function automatic logic bcd_in_range(input logic [7:0] v, input int lo, input int hi);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) &&
           (bcd_value(v) >= lo) && (bcd_value(v) <= hi);
  endfunction

endpackage

// File: rtl/contador_bcd_ad_param_if.sv
// rtl/contador_bcd_ad_param_if.sv - selection, request, load and count signals of one field
interface contador_bcd_ad_param_if;
  logic [3:0] en_count;
  logic       enUP;
  logic       enDOWN;
  logic       load;
  logic [7:0] load_data;
  logic [7:0] data_bcd;
  logic       carry;
  logic       borrow;
  logic       load_err;

  modport master (
    output en_count, enUP, enDOWN, load, load_data,
    input  data_bcd, carry, borrow, load_err
  );

  modport slave (
    input  en_count, enUP, enDOWN, load, load_data,
    output data_bcd, carry, borrow, load_err
  );
endinterface

// File: rtl/gen_autorrepeat.sv
// rtl/gen_autorrepeat.sv - press FSM: one step on press, then delayed auto-repeat while held
module gen_autorrepeat
  import rtc_pkg::*;
#(
  parameter int INIT_DELAY = 50_000_000,
  parameter int REPEAT_DIV = 26_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic req_up,
  input  logic req_dn,
  output logic step_up,
  output logic step_dn
);

  localparam int MAX_DELAY = (INIT_DELAY > REPEAT_DIV) ? INIT_DELAY : REPEAT_DIV;
  localparam int TW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [TW-1:0] INIT_LAST = TW'(INIT_DELAY - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_DIV - 1);
  localparam logic [TW-1:0] T_SAT     = '1;

  press_state_t  state;
  logic [TW-1:0] timer;
  logic          dir_up;
  logic          held;

  // Requests are mutually exclusive, so "held" also catches a direction change.
  assign held = dir_up ? req_up : req_dn;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      timer   <= '0;
      dir_up  <= 1'b0;
      step_up <= 1'b0;
      step_dn <= 1'b0;
    end else begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      case (state)
        IDLE: begin
          if (req_up || req_dn) begin
            state   <= FIRST;
            dir_up  <= req_up;
            timer   <= '0;
            step_up <= req_up;
            step_dn <= req_dn;
          end else if (timer != T_SAT) begin
            timer <= timer + 1'b1;
          end
        end
        FIRST, REPEAT: begin
          if (!held) begin
            state <= IDLE;
            timer <= '0;
          end else if (timer == ((state == FIRST) ? INIT_LAST : REP_LAST)) begin
            state   <= REPEAT;
            timer   <= '0;
            step_up <= dir_up;
            step_dn <= !dir_up;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/contador_bcd_ad_param.sv
// rtl/contador_bcd_ad_param.sv - 2-digit BCD up/down adjust counter with range, load and wrap flags
module contador_bcd_ad_param
  import rtc_pkg::*;
#(
  parameter int MOD_MIN    = 0,
  parameter int MOD_MAX    = 59,
  parameter int SEL_ID     = int'(SEL_SEG),
  parameter int INIT_DELAY = 50_000_000,
  parameter int REPEAT_DIV = 26_000_000
) (
  input logic                    clk,
  input logic                    reset,
  contador_bcd_ad_param_if.slave bus
);

  localparam logic [7:0] MIN_BCD = to_bcd2(MOD_MIN);
  localparam logic [7:0] MAX_BCD = to_bcd2(MOD_MAX);

  logic [7:0] count;
  logic       carry_q, borrow_q, load_err_q;
  logic       selected, req_up, req_dn;
  logic       step_up, step_dn;

  assign selected = (bus.en_count == 4'(SEL_ID));
  assign req_up   = selected && bus.enUP && !bus.enDOWN;
  assign req_dn   = selected && bus.enDOWN && !bus.enUP;

  gen_autorrepeat #(
    .INIT_DELAY (INIT_DELAY),
    .REPEAT_DIV (REPEAT_DIV)
  ) u_autorrepeat (
    .clk     (clk),
    .reset   (reset),
    .req_up  (req_up),
    .req_dn  (req_dn),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      count      <= MIN_BCD;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
      // A load swallows any step arriving in the same cycle.
      if (bus.load) begin
        if (bcd_in_range(bus.load_data, MOD_MIN, MOD_MAX)) count <= bus.load_data;
        else                                               load_err_q <= 1'b1;
      end else if (step_up || step_dn) begin
        if (!bcd_in_range(count, MOD_MIN, MOD_MAX)) begin
          count <= MIN_BCD;
        end else if (step_up) begin
          if (count == MAX_BCD) begin
            count   <= MIN_BCD;
            carry_q <= 1'b1;
          end else begin
            count <= bcd_inc2(count);
          end
        end else begin
          if (count == MIN_BCD) begin
            count    <= MAX_BCD;
            borrow_q <= 1'b1;
          end else begin
            count <= bcd_dec2(count);
          end
        end
      end
    end
  end

  assign bus.data_bcd = count;
  assign bus.carry    = carry_q;
  assign bus.borrow   = borrow_q;
  assign bus.load_err = load_err_q;

endmodule
